// File: rtl/fifo_pkg.sv
// Shared constants for the threshold FIFO and the flow-control machine that consumes its status.
// Holds the parameter defaults, the depth derivation and the machine state encodings.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 6;
  localparam int unsigned ADDR_WIDTH_DEF      = 3;
  localparam int unsigned UMBRAL_ALTO_RST_DEF = 7;
  localparam int unsigned UMBRAL_BAJO_RST_DEF = 1;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  localparam int unsigned DEPTH_DEF = depth_of(ADDR_WIDTH_DEF);

  // Encodings shared with the downstream flow-control machine.
  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } maquina_state_e;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write port, combinational indexed read port.
// Contents are deliberately left unreset.
module fifo_mem import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, sticky error flags
// and registered accept strobes for the flow-control machine.
module fifo_umbrales import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned UMBRAL_ALTO_RST = UMBRAL_ALTO_RST_DEF,
  parameter int unsigned UMBRAL_BAJO_RST = UMBRAL_BAJO_RST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  umbral_load,
  input  logic [ADDR_WIDTH:0]   umbral_alto_in,
  input  logic [ADDR_WIDTH:0]   umbral_bajo_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_write,
  output logic                  fifo_read,
  output logic                  umbral_valid,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DepthCnt = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AltoRst  = UMBRAL_ALTO_RST[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] BajoRst  = UMBRAL_BAJO_RST[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CntOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PtrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  wr_strb_q, rd_strb_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH:0]   alto_q, alto_d;
  logic [ADDR_WIDTH:0]   bajo_q, bajo_d;
  logic                  uvalid_q, uvalid_d;

  logic                  full, empty;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = rd_accept;
    alto_d     = alto_q;
    bajo_d     = bajo_q;
    uvalid_d   = uvalid_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      data_out_d = mem_rdata;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // A load clears the sticky flags, but an error in the same cycle still sets them.
    ovf_d = (ovf_q & ~umbral_load) | (wr_en & full);
    unf_d = (unf_q & ~umbral_load) | (rd_en & empty);

    if (umbral_load) begin
      alto_d   = umbral_alto_in;
      bajo_d   = umbral_bajo_in;
      uvalid_d = (umbral_bajo_in < umbral_alto_in) && (umbral_alto_in <= DepthCnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      wr_strb_q  <= 1'b0;
      rd_strb_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      alto_q     <= AltoRst;
      bajo_q     <= BajoRst;
      uvalid_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      wr_strb_q  <= wr_accept;
      rd_strb_q  <= rd_accept;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
      uvalid_q   <= uvalid_d;
    end
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_q;
  assign fifo_full     = full;
  assign fifo_empty    = empty;
  assign almost_full   = (count_q >= alto_q);
  assign almost_empty  = (count_q <= bajo_q);
  assign fifo_write    = wr_strb_q;
  assign fifo_read     = rd_strb_q;
  assign umbral_valid  = uvalid_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign count         = count_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_umbrales;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       umbral_load = 1'b0;
  logic [5:0] data_in = '0;
  logic [3:0] ua_in = '0;
  logic [3:0] ub_in = '0;

  logic [5:0] data_out;
  logic       valid_out, fifo_full, fifo_empty, almost_full, almost_empty;
  logic       fifo_write, fifo_read, umbral_valid, overflow_err, underflow_err;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  fifo_umbrales dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .data_in        (data_in),
    .rd_en          (rd_en),
    .umbral_load    (umbral_load),
    .umbral_alto_in (ua_in),
    .umbral_bajo_in (ub_in),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .fifo_write     (fifo_write),
    .fifo_read      (fifo_read),
    .umbral_valid   (umbral_valid),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue itself, flags follow from its size.
  logic [5:0] mq[$];
  logic [5:0] m_data = '0;
  bit m_valid = 0, m_ws = 0, m_rs = 0, m_ovf = 0, m_unf = 0, m_uv = 0;
  int m_alto = 7, m_bajo = 1;

  always @(posedge clk or negedge reset) begin
    int sz;
    bit wacc, racc;
    if (!reset) begin
      mq.delete();
      m_data  <= '0;
      m_valid <= 0;
      m_ws    <= 0;
      m_rs    <= 0;
      m_ovf   <= 0;
      m_unf   <= 0;
      m_uv    <= 0;
      m_alto  <= 7;
      m_bajo  <= 1;
    end else begin
      sz   = mq.size();
      wacc = wr_en && (sz < 8);
      racc = rd_en && (sz > 0);
      m_ovf <= (m_ovf && !umbral_load) || (wr_en && sz == 8);
      m_unf <= (m_unf && !umbral_load) || (rd_en && sz == 0);
      if (racc) begin
        m_data <= mq[0];
        mq.pop_front();
      end
      if (wacc) mq.push_back(data_in);
      m_valid <= racc;
      m_ws    <= wacc;
      m_rs    <= racc;
      if (umbral_load) begin
        m_alto <= int'(ua_in);
        m_bajo <= int'(ub_in);
        m_uv   <= (ub_in < ua_in) && (int'(ua_in) <= 8);
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    if (chk_en) begin
      sz = mq.size();
      check("m_count",         int'(count),         sz);
      check("m_fifo_full",     int'(fifo_full),     int'(sz == 8));
      check("m_fifo_empty",    int'(fifo_empty),    int'(sz == 0));
      check("m_almost_full",   int'(almost_full),   int'(sz >= m_alto));
      check("m_almost_empty",  int'(almost_empty),  int'(sz <= m_bajo));
      check("m_data_out",      int'(data_out),      int'(m_data));
      check("m_valid_out",     int'(valid_out),     int'(m_valid));
      check("m_fifo_write",    int'(fifo_write),    int'(m_ws));
      check("m_fifo_read",     int'(fifo_read),     int'(m_rs));
      check("m_umbral_valid",  int'(umbral_valid),  int'(m_uv));
      check("m_overflow_err",  int'(overflow_err),  int'(m_ovf));
      check("m_underflow_err", int'(underflow_err), int'(m_unf));
    end
  end

  // One clock with the given requests; returns 2 time units after the edge.
  task automatic cyc(input bit we, input logic [5:0] d, input bit re);
    wr_en = we;
    data_in = d;
    rd_en = re;
    @(posedge clk);
    #2;
    wr_en = 0;
    rd_en = 0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b);
    umbral_load = 1;
    ua_in = a;
    ub_in = b;
    @(posedge clk);
    #2;
    umbral_load = 0;
  endtask

  initial begin
    int wr_n;
    bit we, re;
    logic [5:0] d;

    repeat (2) @(posedge clk);
    #2;
    reset = 1;
    chk_en = 1;

    // Reset then idle
    cyc(0, '0, 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_almost_empty", int'(almost_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_umbral_valid", int'(umbral_valid), 0);
    check("rst_strobes", int'({valid_out, fifo_write, fifo_read}), 0);
    check("rst_errors", int'({overflow_err, underflow_err}), 0);

    // Thresholds 6/2, six writes
    load(4'd6, 4'd2);
    check("ld_valid_6_2", int'(umbral_valid), 1);
    for (int i = 1; i <= 6; i++) begin
      d = 6'(i);
      cyc(1, d, 0);
      check("wr_strobe", int'(fifo_write), 1);
      if (i == 5) check("af_at_5", int'(almost_full), 0);
    end
    check("af_at_6", int'(almost_full), 1);
    check("count_6", int'(count), 6);
    load(4'd2, 4'd5);
    check("ld_invalid_2_5", int'(umbral_valid), 0);
    check("ld_keeps_count", int'(count), 6);
    check("ld_af_reeval", int'(almost_full), 1);
    check("ld_ae_reeval", int'(almost_empty), 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, '0, 1);
      check("rd1_valid", int'(valid_out), 1);
      check("rd1_data", int'(data_out), i);
    end
    cyc(0, '0, 0);
    check("hold_valid", int'(valid_out), 0);
    check("hold_data", int'(data_out), 6);

    // Fill and overflow
    for (int i = 0; i < 8; i++) begin
      d = 6'(8'h10 + i);
      cyc(1, d, 0);
    end
    check("full_flag", int'(fifo_full), 1);
    cyc(1, 6'h3F, 0);
    check("full_count", int'(count), 8);
    check("ovf_set", int'(overflow_err), 1);
    check("ovf_no_strobe", int'(fifo_write), 0);
    cyc(0, '0, 0);
    check("ovf_sticky", int'(overflow_err), 1);

    // Full with simultaneous read and write
    cyc(1, 6'h2A, 1);
    check("fs_count", int'(count), 7);
    check("fs_data", int'(data_out), 'h10);
    check("fs_rd", int'(fifo_read), 1);
    check("fs_wr", int'(fifo_write), 0);
    for (int i = 1; i < 8; i++) begin
      cyc(0, '0, 1);
      check("rd2_valid", int'(valid_out), 1);
      check("rd2_data", int'(data_out), 'h10 + i);
    end
    check("drained", int'(fifo_empty), 1);

    // Empty with simultaneous read and write
    cyc(1, 6'h33, 1);
    check("es_count", int'(count), 1);
    check("es_unf", int'(underflow_err), 1);
    check("es_valid", int'(valid_out), 0);
    check("es_ovf_kept", int'(overflow_err), 1);
    load(4'd6, 4'd2);
    check("ld_clr_ovf", int'(overflow_err), 0);
    check("ld_clr_unf", int'(underflow_err), 0);
    check("ld_clr_count", int'(count), 1);
    cyc(0, '0, 1);
    check("ld_data_kept", int'(data_out), 'h33);

    // Random interleaved stream of 20 words
    wr_n = 0;
    for (int c = 0; c < 400 && !(wr_n == 20 && mq.size() == 0); c++) begin
      we = (wr_n < 20) && ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 2) != 0);
      d = 6'($urandom_range(0, 63));
      if (we && mq.size() < 8) wr_n++;
      cyc(we, d, re);
    end
    check("stream_done", int'(wr_n == 20 && count == 0), 1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      d = 6'(8'h20 + i);
      cyc(1, d, 0);
    end
    check("pre_rst_count", int'(count), 5);
    wr_en = 1;
    rd_en = 1;
    #1 reset = 0;
    #1;
    wr_en = 0;
    rd_en = 0;
    check("arst_count", int'(count), 0);
    check("arst_empty", int'(fifo_empty), 1);
    check("arst_ae", int'(almost_empty), 1);
    check("arst_af", int'(almost_full), 0);
    check("arst_data", int'(data_out), 0);
    check("arst_strobes", int'({valid_out, fifo_write, fifo_read}), 0);
    check("arst_errors", int'({overflow_err, underflow_err}), 0);
    check("arst_uvalid", int'(umbral_valid), 0);
    #2 reset = 1;
    cyc(0, '0, 0);
    check("post_rst_strobes", int'({valid_out, fifo_write, fifo_read}), 0);
    check("post_rst_count", int'(count), 0);

    cyc(0, '0, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
